uart_core: RTL and testbench
============================

# uart_core

Synthesizable, parametrised full-duplex UART transceiver that replaces behavioural serial models on the FPGA and SoC side of the design. Converts parallel words to and from asynchronous serial frames with configurable data width, parity and stop bits. Both directions use a ready/valid interface, and received words are buffered in a FIFO. Sits between the MMIO serial peripheral and the board `txd`/`rxd` pins, and is cross-checked against the existing simulation UART model.

## Interface
- `CLOCK_FREQ`, 100_000_000: core clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate. `DIV = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE`; elaboration fails if `DIV < 4`.
- `DATA_BITS`, 8: payload width, legal values 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `RX_FIFO_DEPTH`, 8: power of two, at least 2. Used only when the FIFO macro is defined.
- `clock`  in  1  core clock; all state is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `io_tx_valid`  in  1  transmit word offered.
- `io_tx_ready`  out  1  transmitter idle and able to accept a word.
- `io_tx_bits`  in  DATA_BITS  transmit word, sent LSB first.
- `io_rx_valid`  out  1  received word available.
- `io_rx_ready`  in  1  consumer accepts the received word.
- `io_rx_bits`  out  DATA_BITS  received word.
- `io_rx_parity_err`  out  1  parity mismatch on `io_rx_bits`; meaningful only while `io_rx_valid` is high.
- `io_rx_frame_err`  out  1  first stop bit sampled low; meaningful only while `io_rx_valid` is high.
- `io_rx_overrun`  out  1  one-cycle pulse when a completed word is dropped.
- `io_txd`  out  1  serial output; idle level is high.
- `io_rxd`  in  1  serial input; asynchronous to `clock`.

## Operation
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Parity bit: odd parity = ~^data; even parity = ^data.
- TX state machine: TX_IDLE → TX_START → TX_DATA → TX_PARITY (only if PARITY≠0) → TX_STOP → TX_IDLE.
  - Each state holds the line for exactly DIV cycles per bit.
  - A bit counter advances through TX_DATA and, when STOP_BITS=2, through TX_STOP.
- `io_tx_ready` = (state == TX_IDLE). A handshake (valid & ready) latches `io_tx_bits` into a shift register. After the latch, `io_tx_bits` is don't-care.
- RX input path: `io_rxd` passes through a 2-FF synchronizer, reset to 1.
- RX state machine: RX_IDLE → RX_START → RX_DATA → RX_PARITY (if enabled) → RX_STOP → RX_IDLE.
  - RX_IDLE: a synchronized falling edge starts a wait of DIV/2 cycles, then the line is resampled.
  - If the resampled line is high, the event is a glitch: return to RX_IDLE and push nothing.
  - Otherwise each later bit is sampled every DIV cycles at mid-bit.
  - Only the first stop bit is checked. The receiver returns to RX_IDLE right after sampling it, so a second stop bit is treated as idle time.
- At the stop-bit sample the receiver pushes {frame_err, parity_err, data} into the receive buffer.
  - If the buffer is full, the word is dropped and `io_rx_overrun` pulses.
  - A pop happening in the same cycle frees a slot first, so push and pop on a full buffer is not an overrun.
- Receive buffer handshake: a word is consumed when `io_rx_valid & io_rx_ready`. Pointers wrap modulo the buffer depth.

## Timing
- Reset values: `io_txd`=1, `io_tx_ready`=1, `io_rx_valid`=0, `io_rx_parity_err`=0, `io_rx_frame_err`=0, `io_rx_overrun`=0, receive buffer empty, both FSMs idle.
- TX latency: for a handshake in cycle N, `io_txd` goes low in cycle N+1.
  - The frame lasts F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles.
  - `io_tx_ready` rises in cycle N+1+F.
- RX latency: `io_rx_valid` rises 1 cycle after the stop-bit sample.
- Back-to-back RX frames: a start edge arriving in the cycle right after the stop-bit sample is accepted.
- Reset mid-frame: takes effect immediately, regardless of clock.
  - `io_txd` returns to 1 and any partial frame is abandoned.
  - All buffered received words are discarded.
  - After release, the receiver ignores a line that is already low until it has been high for at least 1 cycle.

## Configuration
- Macro: `UART_RX_FIFO_EN`.
- Defined: the receive buffer is a `uart_fifo` instance of depth RX_FIFO_DEPTH.
- Undefined: the receive buffer is a single holding register, effectively depth 1. `RX_FIFO_DEPTH` is ignored.
- Port list and handshake rules are identical in both builds.

## Structure
- `uart_pkg` holds:
  - the parity enum `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN`;
  - the `tx_state_e` and `rx_state_e` enums;
  - a `uart_div` function implementing the DIV rounding.
- One sub-module, `uart_fifo`: a synchronous FIFO parametrised by width and depth, with full/empty flags.
- TX and RX state machines stay inside `uart_core`.

## Test plan
All scenarios use CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000, so DIV=10.
- TX 8N1: send 0xA5 → `io_txd` is low for 10 cycles, then carries bits 1,0,1,0,0,1,0,1 at 10 cycles each, then is high. `io_tx_ready` returns 100 cycles after `io_txd` first went low.
- Loopback with even parity and 2 stop bits (`io_txd`→`io_rxd`): send 0x3C → RX delivers 0x3C with both error flags 0. TX transmits parity bit 0 (four ones). TX frame is 120 cycles.
- Frame error: drive a frame carrying 0x55 with the stop bit low → `io_rx_bits`=0x55 and `io_rx_frame_err`=1.
- Glitch rejection: a 3-cycle low pulse on `io_rxd` → no word pushed and `io_rx_valid` stays 0.
- Overrun, FIFO build with RX_FIFO_DEPTH=4 and `io_rx_ready`=0: send 5 frames → the 5th pulses `io_rx_overrun`. Draining returns exactly the first 4 words, in order.
- Reset mid-frame: assert `reset_n`=0 during the 4th data bit of TX and RX → `io_txd`=1, `io_tx_ready`=1, `io_rx_valid`=0 asynchronously. The next full frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int uart_div(input int clock_freq, input int baud_rate);
    return (clock_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, power-of-two depth; a pop in the same cycle frees a slot for a push.
module uart_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE;
      if (do_pop)  rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with ready/valid on both sides. Define UART_RX_FIFO_EN for a
// uart_fifo receive buffer of RX_FIFO_DEPTH; otherwise a single holding register.
module uart_core import uart_pkg::*; #(
  parameter int CLOCK_FREQ    = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 io_tx_valid,
  output logic                 io_tx_ready,
  input  logic [DATA_BITS-1:0] io_tx_bits,
  output logic                 io_rx_valid,
  input  logic                 io_rx_ready,
  output logic [DATA_BITS-1:0] io_rx_bits,
  output logic                 io_rx_parity_err,
  output logic                 io_rx_frame_err,
  output logic                 io_rx_overrun,
  output logic                 io_txd,
  input  logic                 io_rxd
);
  localparam int              DIV        = uart_div(CLOCK_FREQ, BAUD_RATE);
  localparam int              CW         = $clog2(DIV);
  localparam logic [CW-1:0]   BIT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0]   HALF_LAST  = CW'(DIV / 2 - 1);
  localparam logic [3:0]      DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST  = 4'(STOP_BITS - 1);
  localparam bit              HAS_PARITY = (PARITY != 0);
  localparam int              EW         = DATA_BITS + 2;

  if (DIV < 4) begin : g_bad_div
    $error("uart_core: DIV must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
    $error("uart_core: illegal frame format");
  end
  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_core: RX_FIFO_DEPTH must be a power of two >= 2");
  end

  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    return (PARITY == int'(PARITY_ODD)) ? ~^d : ^d;
  endfunction

  // ---------------- transmitter ----------------
  tx_state_e            tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par, tx_fire, tx_tick;

  assign io_tx_ready = (tx_state == TX_IDLE);
  assign tx_fire     = io_tx_valid & io_tx_ready;
  assign tx_tick     = (tx_cnt == BIT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (tx_fire) tx_next = TX_START;
      TX_START:  if (tx_tick) tx_next = TX_DATA;
      TX_DATA:   if (tx_tick && tx_bit == DATA_LAST) tx_next = HAS_PARITY ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tick) tx_next = TX_STOP;
      TX_STOP:   if (tx_tick && tx_bit == STOP_LAST) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
    end else if (tx_fire) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= io_tx_bits;
      tx_par   <= calc_par(io_tx_bits);
    end else if (tx_state != TX_IDLE) begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
      if (tx_tick) begin
        // bit index restarts on every state change; counts data and stop bits
        tx_bit <= (tx_next != tx_state) ? '0 : tx_bit + 1'b1;
        if (tx_state == TX_DATA) tx_shreg <= tx_shreg >> 1;
      end
    end
  end

  always_comb begin
    case (tx_state)
      TX_START:  io_txd = 1'b0;
      TX_DATA:   io_txd = tx_shreg[0];
      TX_PARITY: io_txd = tx_par;
      default:   io_txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic       rx_s1, rx_s2, rx_prev, rx_fall;
  logic [1:0] rx_primed;

  // rx_prev only arms once the synchronizer holds a real line sample that is high,
  // so a line already low at reset release never looks like a start edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b0;
      rx_primed <= '0;
    end else begin
      rx_s1     <= io_rxd;
      rx_s2     <= rx_s1;
      rx_primed <= {rx_primed[0], 1'b1};
      rx_prev   <= rx_s2 & rx_primed[1];
    end
  end
  assign rx_fall = rx_prev & ~rx_s2;

  rx_state_e            rx_state, rx_next;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par, rx_half, rx_tick, rx_push;
  logic [EW-1:0]        rx_entry;

  assign rx_half = (rx_cnt == HALF_LAST);
  assign rx_tick = (rx_cnt == BIT_LAST);
  assign rx_push = (rx_state == RX_STOP) && rx_tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_fall) rx_next = RX_START;
      RX_START:  if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_tick && rx_bit == DATA_LAST) rx_next = HAS_PARITY ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tick) rx_next = RX_STOP;
      RX_STOP:   if (rx_tick) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_par   <= 1'b0;
    end else begin
      if (rx_next != rx_state || rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                                       rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (rx_state == RX_PARITY && rx_tick) rx_par <= rx_s2;
    end
  end

  assign rx_entry = {~rx_s2, HAS_PARITY && (rx_par != calc_par(rx_shreg)), rx_shreg};

  // ---------------- receive buffer ----------------
  logic [EW-1:0] rx_head;
  logic          buf_full, buf_empty, rx_pop, rx_overrun_q;

  assign rx_pop = io_rx_valid & io_rx_ready;

`ifdef UART_RX_FIFO_EN
  uart_fifo #(.WIDTH(EW), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (rx_push),
    .wdata   (rx_entry),
    .pop     (rx_pop),
    .rdata   (rx_head),
    .full    (buf_full),
    .empty   (buf_empty)
  );
`else
  logic          hold_vld;
  logic [EW-1:0] hold_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else if (rx_push && (!hold_vld || rx_pop)) begin
      hold_vld <= 1'b1;
      hold_q   <= rx_entry;
    end else if (rx_pop) begin
      hold_vld <= 1'b0;
    end
  end
  assign buf_full  = hold_vld;
  assign buf_empty = ~hold_vld;
  assign rx_head   = hold_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_overrun_q <= 1'b0;
    else          rx_overrun_q <= rx_push & buf_full & ~rx_pop;
  end

  assign io_rx_valid      = ~buf_empty;
  assign io_rx_bits       = rx_head[DATA_BITS-1:0];
  assign io_rx_parity_err = io_rx_valid & rx_head[DATA_BITS];
  assign io_rx_frame_err  = io_rx_valid & rx_head[DATA_BITS+1];
  assign io_rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench: instance a is 8N1 driven from the bench, instance b is 8E2 in loopback.
module tb_uart_core;
  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int DIV = 10;
`ifdef UART_RX_FIFO_EN
  localparam int EXP_DEPTH = 4;
`else
  localparam int EXP_DEPTH = 1;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic       a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready, a_perr, a_ferr, a_ovr, a_txd, a_rxd;
  logic [7:0] a_tx_bits, a_rx_bits;
  logic       b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready, b_perr, b_ferr, b_ovr, b_txd;
  logic [7:0] b_tx_bits, b_rx_bits;

  int checks = 0;
  int failures = 0;
  int a_ovr_cnt = 0;
  logic frm[$];

  uart_core #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
              .RX_FIFO_DEPTH(4)) u_a (
    .clock(clock), .reset_n(reset_n),
    .io_tx_valid(a_tx_valid), .io_tx_ready(a_tx_ready), .io_tx_bits(a_tx_bits),
    .io_rx_valid(a_rx_valid), .io_rx_ready(a_rx_ready), .io_rx_bits(a_rx_bits),
    .io_rx_parity_err(a_perr), .io_rx_frame_err(a_ferr), .io_rx_overrun(a_ovr),
    .io_txd(a_txd), .io_rxd(a_rxd)
  );

  uart_core #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
              .RX_FIFO_DEPTH(4)) u_b (
    .clock(clock), .reset_n(reset_n),
    .io_tx_valid(b_tx_valid), .io_tx_ready(b_tx_ready), .io_tx_bits(b_tx_bits),
    .io_rx_valid(b_rx_valid), .io_rx_ready(b_rx_ready), .io_rx_bits(b_rx_bits),
    .io_rx_parity_err(b_perr), .io_rx_frame_err(b_ferr), .io_rx_overrun(b_ovr),
    .io_txd(b_txd), .io_rxd(b_txd)
  );

  always @(negedge clock) if (a_ovr === 1'b1) a_ovr_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Reference frame: start, data LSB first, parity from the count of ones, stop bits.
  task automatic make_frame(input logic [7:0] d, input int par, input int stops);
    int n;
    n = 0;
    frm.delete();
    frm.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      frm.push_back(d[i]);
      n += int'(d[i]);
    end
    if (par == 2) frm.push_back(n % 2 == 1);
    else if (par == 1) frm.push_back(n % 2 == 0);
    for (int i = 0; i < stops; i++) frm.push_back(1'b1);
  endtask

  task automatic send_tx(input bit use_b, input logic [7:0] d, input string nm);
    int f, bad;
    logic txd_o, rdy_o;
    make_frame(d, use_b ? 2 : 0, use_b ? 2 : 1);
    f = frm.size() * DIV;
    bad = 0;
    @(negedge clock);
    rdy_o = use_b ? b_tx_ready : a_tx_ready;
    checks++;
    if (rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_idle got=%b exp=1", nm, rdy_o);
    end
    if (use_b) begin b_tx_valid = 1'b1; b_tx_bits = d; end
    else       begin a_tx_valid = 1'b1; a_tx_bits = d; end
    @(negedge clock);
    a_tx_valid = 1'b0; b_tx_valid = 1'b0;
    a_tx_bits = 8'($urandom); b_tx_bits = 8'($urandom);
    for (int c = 0; c < f; c++) begin
      txd_o = use_b ? b_txd : a_txd;
      rdy_o = use_b ? b_tx_ready : a_tx_ready;
      if (txd_o !== frm[c / DIV] || rdy_o !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_frame data=%h bad_cycles=%0d exp=0 of %0d", nm, d, bad, f);
    end
    txd_o = use_b ? b_txd : a_txd;
    rdy_o = use_b ? b_tx_ready : a_tx_ready;
    checks++;
    if ({txd_o, rdy_o} !== 2'b11) begin
      failures++;
      $display("FAIL %s_ready_after got txd,ready=%b%b exp=11", nm, txd_o, rdy_o);
    end
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop_lvl);
    make_frame(d, 0, 1);
    frm[frm.size() - 1] = stop_lvl;
    for (int i = 0; i < frm.size(); i++) begin
      a_rxd = frm[i];
      repeat (DIV) @(negedge clock);
    end
    a_rxd = 1'b1;
  endtask

  task automatic rx_expect(input bit use_b, input logic [7:0] d, input logic fe, input string nm);
    int k;
    logic [10:0] got;
    k = 0;
    while (k < 4 * DIV && (use_b ? b_rx_valid : a_rx_valid) !== 1'b1) begin
      @(negedge clock);
      k++;
    end
    got = use_b ? {b_rx_valid, b_ferr, b_perr, b_rx_bits} : {a_rx_valid, a_ferr, a_perr, a_rx_bits};
    checks++;
    if (got !== {1'b1, fe, 1'b0, d}) begin
      failures++;
      $display("FAIL %s_rx got valid,ferr,perr,bits=%h exp=%h", nm, got, {1'b1, fe, 1'b0, d});
    end
    if (use_b) b_rx_ready = 1'b1; else a_rx_ready = 1'b1;
    @(negedge clock);
    a_rx_ready = 1'b0; b_rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    a_tx_valid = 0; a_tx_bits = 0; a_rx_ready = 0; a_rxd = 1;
    b_tx_valid = 0; b_tx_bits = 0; b_rx_ready = 0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({a_txd, a_tx_ready, a_rx_valid, a_perr, a_ferr, a_ovr} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_a got=%b exp=110000", {a_txd, a_tx_ready, a_rx_valid, a_perr, a_ferr, a_ovr});
    end
    checks++;
    if ({b_txd, b_tx_ready, b_rx_valid, b_perr, b_ferr, b_ovr} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_b got=%b exp=110000", {b_txd, b_tx_ready, b_rx_valid, b_perr, b_ferr, b_ovr});
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_tx;
    send_tx(1'b0, 8'hA5, "tx_a5");
    for (int i = 0; i < 3; i++) send_tx(1'b0, 8'($urandom), "tx_rand");
  endtask

  task automatic test_rx;
    logic [7:0] d;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      drive_rx(d, 1'b1);
      rx_expect(1'b0, d, 1'b0, "rx_rand");
      checks++;
      if (a_rx_valid !== 1'b0) begin
        failures++;
        $display("FAIL rx_pop_empty got valid=%b exp=0", a_rx_valid);
      end
      repeat ($urandom_range(0, 15)) @(negedge clock);
    end
  endtask

  task automatic test_frame_err;
    drive_rx(8'h55, 1'b0);
    rx_expect(1'b0, 8'h55, 1'b1, "frame_err");
    repeat (2 * DIV) @(negedge clock);
  endtask

  task automatic test_glitch;
    int seen;
    seen = 0;
    a_rxd = 1'b0;
    repeat (3) @(negedge clock);
    a_rxd = 1'b1;
    for (int c = 0; c < 4 * DIV; c++) begin
      if (a_rx_valid !== 1'b0) seen++;
      @(negedge clock);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL glitch valid_cycles=%0d exp=0", seen);
    end
  endtask

  task automatic test_overrun;
    logic [7:0] q[$];
    logic [7:0] d;
    a_ovr_cnt = 0;
    for (int i = 0; i <= EXP_DEPTH; i++) begin
      if (i == EXP_DEPTH) begin
        checks++;
        if (a_ovr_cnt != 0) begin
          failures++;
          $display("FAIL overrun_early pulses=%0d exp=0", a_ovr_cnt);
        end
      end
      d = 8'($urandom);
      q.push_back(d);
      drive_rx(d, 1'b1);
    end
    repeat (2 * DIV) @(negedge clock);
    checks++;
    if (a_ovr_cnt != 1) begin
      failures++;
      $display("FAIL overrun_pulse pulses=%0d exp=1", a_ovr_cnt);
    end
    for (int i = 0; i < EXP_DEPTH; i++) rx_expect(1'b0, q[i], 1'b0, "overrun_drain");
    checks++;
    if (a_rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_drained got valid=%b exp=0", a_rx_valid);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] d;
    send_tx(1'b1, 8'h3C, "loop_3c");
    rx_expect(1'b1, 8'h3C, 1'b0, "loop_3c");
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      send_tx(1'b1, d, "loop_rand");
      rx_expect(1'b1, d, 1'b0, "loop_rand");
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d0, d2, d3;
    logic rf[$];
    int seen;
    d0 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
    drive_rx(d0, 1'b1);
    repeat (3) @(negedge clock);
    make_frame(d2, 0, 1);
    rf = frm;
    @(negedge clock);
    a_tx_valid = 1'b1; a_tx_bits = 8'($urandom); a_rxd = rf[0];
    for (int k = 1; k <= 4 * DIV + 5; k++) begin
      @(negedge clock);
      a_tx_valid = 1'b0;
      a_rxd = rf[k / DIV];
    end
    checks++;
    if ({a_tx_ready, a_rx_valid} !== 2'b01) begin
      failures++;
      $display("FAIL mid_before got ready,valid=%b exp=01", {a_tx_ready, a_rx_valid});
    end
    #2 reset_n = 1'b0;
    a_rxd = 1'b0;
    #1;
    checks++;
    if ({a_txd, a_tx_ready, a_rx_valid} !== 3'b110) begin
      failures++;
      $display("FAIL mid_async got txd,ready,valid=%b exp=110", {a_txd, a_tx_ready, a_rx_valid});
    end
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 3 * DIV; c++) begin
      if (a_rx_valid !== 1'b0) seen++;
      @(negedge clock);
    end
    a_rxd = 1'b1;
    for (int c = 0; c < 2 * DIV; c++) begin
      if (a_rx_valid !== 1'b0) seen++;
      @(negedge clock);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_low_line valid_cycles=%0d exp=0", seen);
    end
    drive_rx(d3, 1'b1);
    rx_expect(1'b0, d3, 1'b0, "mid_next");
    send_tx(1'b0, d3, "mid_tx");
  endtask

  initial begin
    test_reset;
    test_tx;
    test_rx;
    test_frame_err;
    test_glitch;
    test_overrun;
    test_loopback;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
